// File: rtl/ps2_keyboard_fifo_if.sv
// Keyboard-port signal bundle between PS/2 pins, MIO bus read strobe and the
// receiver/FIFO block.
interface ps2_keyboard_fifo_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       io_rdn;
    logic [7:0] key_data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_data, io_rdn,
        input  key_data, ready, overflow, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data, io_rdn,
        output key_data, ready, overflow, frame_err
    );
endinterface

// File: rtl/ps2_keyboard_fifo.sv
// PS/2 keyboard frame receiver feeding an 8-entry scan-code FIFO that the CPU
// drains one byte per I/O read strobe.
module ps2_keyboard_fifo #(
    parameter int unsigned FIFO_AW        = 3,
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic               clk,
    input  logic               rst,
    ps2_keyboard_fifo_if.slave kb
);
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = FIFO_AW + 1;
    localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [3:0] BC_IDLE  = 4'd0;
    localparam logic [3:0] BC_FIRST = 4'd1;
    localparam logic [3:0] BC_STOP  = 4'd10;

    logic          clk_s1, clk_s2, clk_s3;
    logic          dat_s1, dat_s2;
    logic          fall;
    logic [3:0]    bc, bc_nxt;
    logic [8:0]    sr, sr_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic          push_c, err_c;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [CW-1:0]      count, count_nxt;
    logic               io_rdn_q;
    logic               pop_c, full_c, do_push_c;

    // Two-flop synchronisers plus a history flop on the clock for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_s3 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= kb.ps2_clk;
            clk_s2 <= clk_s1;
            clk_s3 <= clk_s2;
            dat_s1 <= kb.ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    assign fall = clk_s3 & ~clk_s2;

    // Receiver state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bc   <= BC_IDLE;
            sr   <= '0;
            tcnt <= '0;
        end else begin
            bc   <= bc_nxt;
            sr   <= sr_nxt;
            tcnt <= tcnt_nxt;
        end
    end

    // sr collects data LSB-first then parity; ^sr is data XOR parity at stop time
    always_comb begin
        bc_nxt   = bc;
        sr_nxt   = sr;
        tcnt_nxt = tcnt;
        push_c   = 1'b0;
        err_c    = 1'b0;
        if (fall) begin
            tcnt_nxt = '0;
            if (bc == BC_IDLE) begin
                if (dat_s2) err_c  = 1'b1;
                else        bc_nxt = BC_FIRST;
            end else if (bc == BC_STOP) begin
                bc_nxt = BC_IDLE;
                if (dat_s2 && (^sr)) push_c = 1'b1;
                else                 err_c  = 1'b1;
            end else begin
                sr_nxt = {dat_s2, sr[8:1]};
                bc_nxt = bc + 4'd1;
            end
        end else if (bc == BC_IDLE) begin
            tcnt_nxt = '0;
        end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            bc_nxt   = BC_IDLE;
            tcnt_nxt = '0;
            err_c    = 1'b1;
        end else begin
            tcnt_nxt = tcnt + TW'(1);
        end
    end

    // A pop frees a slot in the same edge, so a full FIFO still accepts the push
    assign pop_c     = kb.io_rdn & ~io_rdn_q & kb.ready;
    assign full_c    = (count == CW'(DEPTH));
    assign do_push_c = push_c & (~full_c | pop_c);
    assign rd_nxt    = pop_c ? rd_ptr + FIFO_AW'(1) : rd_ptr;

    always_comb begin
        count_nxt = count;
        if (do_push_c && !pop_c)      count_nxt = count + CW'(1);
        else if (pop_c && !do_push_c) count_nxt = count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (do_push_c) mem[wr_ptr] <= sr[7:0];
    end

    // Head byte is registered from the post-update read pointer, bypassing a
    // byte that lands in the head slot on this same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io_rdn_q     <= 1'b1;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            kb.ready     <= 1'b0;
            kb.overflow  <= 1'b0;
            kb.frame_err <= 1'b0;
            kb.key_data  <= '0;
        end else begin
            io_rdn_q     <= kb.io_rdn;
            rd_ptr       <= rd_nxt;
            count        <= count_nxt;
            kb.ready     <= (count_nxt != '0);
            kb.frame_err <= err_c;
            if (do_push_c)                  wr_ptr      <= wr_ptr + FIFO_AW'(1);
            if (push_c && full_c && !pop_c) kb.overflow <= 1'b1;
            kb.key_data <= (do_push_c && (wr_ptr == rd_nxt)) ? sr[7:0] : mem[rd_nxt];
        end
    end
endmodule
